fetch_seq: RTL and testbench

- Instruction-fetch sequencer for the DSP core. Owns the program counter and drives the byte address of the combinational 16-bit instruction memory.
- Registers the returned instruction into a fetch/decode register.
- Next-PC sources: sequential step, branch redirect, and a single-level zero-overhead hardware loop.
- Sits between instruction memory and decode.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_seq_if.sv | 44 ++++
 rtl/fetch_seq_loop_ctrl.sv | 66 ++++++
 rtl/fetch_seq.sv | 102 ++++++++++
 tb/tb_fetch_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
//   state_t : sequencer FSM states (IDLE parked, RUN fetching)
//   ADDR_W / INSTR_W / CNT_W : default widths used by the interface and modules
//   PC_STEP : byte increment between consecutive 16-bit instructions
package fetch_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 10;
  localparam int PC_STEP = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// Bus bundle between the fetch sequencer, its instruction memory and decode.
//   Control in   : en, stall, br_valid, br_target
//   Loop setup   : loop_set, loop_start, loop_end, loop_count
//   Memory       : imem_addr (to memory), imem_instr (from memory, same cycle)
//   Fetch output : if_valid, if_instr, if_pc
//   Loop status  : loop_active, loop_err
// Modports: master = the sequencer, slave = the surrounding core / memory.
interface fetch_seq_if #(
  parameter int ADDR_W  = fetch_pkg::ADDR_W,
  parameter int INSTR_W = fetch_pkg::INSTR_W,
  parameter int CNT_W   = fetch_pkg::CNT_W
);

  logic               en;
  logic               stall;
  logic               br_valid;
  logic [ADDR_W-1:0]  br_target;
  logic               loop_set;
  logic [ADDR_W-1:0]  loop_start;
  logic [ADDR_W-1:0]  loop_end;
  logic [CNT_W-1:0]   loop_count;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               loop_active;
  logic               loop_err;

  modport master (
    input  en, stall, br_valid, br_target,
    input  loop_set, loop_start, loop_end, loop_count,
    input  imem_instr,
    output imem_addr, if_valid, if_instr, if_pc, loop_active, loop_err
  );

  modport slave (
    output en, stall, br_valid, br_target,
    output loop_set, loop_start, loop_end, loop_count,
    output imem_instr,
    input  imem_addr, if_valid, if_instr, if_pc, loop_active, loop_err
  );

endinterface

// File: rtl/fetch_seq_loop_ctrl.sv
// Single-level zero-overhead hardware loop controller.
//   clk, rst_n   : clock, async active-low reset
//   pc           : current program counter
//   advance      : a fetch capture happens this edge (loop decision may fire)
//   set, set_*   : loop register load request and its start/end/count
//   start        : registered loop start address (halfword aligned)
//   hit          : loop armed and pc sits on the loop end
//   last         : iteration counter is on its final pass
//   active, err  : loop armed; sticky "set while armed" error
module loop_ctrl #(
  parameter int ADDR_W = fetch_pkg::ADDR_W,
  parameter int CNT_W  = fetch_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              advance,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_start,
  input  logic [ADDR_W-1:0] set_end,
  input  logic [CNT_W-1:0]  set_count,
  output logic [ADDR_W-1:0] start,
  output logic              hit,
  output logic              last,
  output logic              active,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  logic [ADDR_W-1:0] end_q;
  logic [CNT_W-1:0]  cnt_q;

  assign hit  = active && (pc == end_q);
  assign last = (cnt_q == CNT_W'(1));

  // NOTE: every register here, address holders included, gets a reset value
  // so a mid-loop reset leaves no stale loop state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start  <= '0;
      end_q  <= '0;
      cnt_q  <= '0;
      active <= 1'b0;
      err    <= 1'b0;
    end else begin
      // hit implies active, so this never collides with an accepted load below.
      if (advance && hit) begin
        if (last) active <= 1'b0;
        else      cnt_q  <= cnt_q - CNT_W'(1);
      end
      // Acceptance uses the pre-edge active value.
      if (set) begin
        if (active) begin
          err <= 1'b1;
        end else if (set_count != '0) begin
          start  <= set_start & ALIGN_MASK;
          end_q  <= set_end & ALIGN_MASK;
          cnt_q  <= set_count;
          active <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, addresses the combinational
// instruction memory and registers the returned instruction for decode.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_seq_if master (control, loop setup, memory, fetch
//                register outputs, loop status)
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = fetch_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_seq_if.master  bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] loop_start_q;
  logic              capture;
  logic              drop;
  logic              loop_hit;
  logic              loop_last;

  assign bus.imem_addr = pc;
  assign pc_seq        = pc + ADDR_W'(PC_STEP);
  // Loop-back is chosen combinationally so the jump costs no bubble.
  assign next_pc       = (loop_hit && !loop_last) ? loop_start_q : pc_seq;

  loop_ctrl #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_loop_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .advance   (capture),
    .set       (bus.loop_set),
    .set_start (bus.loop_start),
    .set_end   (bus.loop_end),
    .set_count (bus.loop_count),
    .start     (loop_start_q),
    .hit       (loop_hit),
    .last      (loop_last),
    .active    (bus.loop_active),
    .err       (bus.loop_err)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output is defaulted first so no path infers a latch.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: if (bus.en) state_next = RUN;
      RUN: begin
        if (!bus.en) begin
          state_next = IDLE;
          drop       = 1'b1;
        end else if (!bus.stall) begin
          capture = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // A redirect kills this cycle's wrong-path fetch regardless of en/stall.
    if (bus.br_valid) capture = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      bus.if_valid <= 1'b0;
      bus.if_instr <= '0;
      bus.if_pc    <= '0;
    end else if (bus.br_valid) begin
      pc           <= bus.br_target & ALIGN_MASK;
      bus.if_valid <= 1'b0;
    end else if (drop) begin
      bus.if_valid <= 1'b0;
    end else if (capture) begin
      bus.if_instr <= bus.imem_instr;
      bus.if_pc    <= pc;
      bus.if_valid <= 1'b1;
      pc           <= next_pc;
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed self-checking bench for fetch_seq. The instruction memory returns
// its own byte address as the instruction word, so if_instr must equal if_pc.
module tb_fetch_seq;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;
  localparam int CNT_W   = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  fetch_seq_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  assign bus.imem_instr = INSTR_W'(bus.imem_addr);

  fetch_seq #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (12'h000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [11:0] exp_pc, input logic [11:0] exp_addr);
    check({tag, ".valid"}, 32'(bus.if_valid), 32'd1);
    check({tag, ".if_pc"}, 32'(bus.if_pc), 32'(exp_pc));
    check({tag, ".instr"}, 32'(bus.if_instr), 32'(exp_pc));
    check({tag, ".addr"},  32'(bus.imem_addr), 32'(exp_addr));
  endtask

  logic [11:0] loop_pc  [11] = '{12'h010, 12'h012, 12'h014, 12'h010, 12'h012, 12'h014,
                                 12'h010, 12'h012, 12'h014, 12'h016, 12'h018};
  logic        loop_act [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.stall = 1'b0;
    bus.br_valid = 1'b0;
    bus.br_target = '0;
    bus.loop_set = 1'b0;
    bus.loop_start = '0;
    bus.loop_end = '0;
    bus.loop_count = '0;

    // Reset state
    #3;
    check("rst.addr",   32'(bus.imem_addr), 32'h000);
    check("rst.valid",  32'(bus.if_valid), 32'd0);
    check("rst.if_pc",  32'(bus.if_pc), 32'h000);
    check("rst.instr",  32'(bus.if_instr), 32'h000);
    check("rst.active", 32'(bus.loop_active), 32'd0);
    check("rst.err",    32'(bus.loop_err), 32'd0);

    // Sequential run: first capture two edges after en rises
    step();
    rst_n = 1'b1;
    bus.en = 1'b1;
    step();
    check("run0.valid", 32'(bus.if_valid), 32'd0);
    check("run0.addr",  32'(bus.imem_addr), 32'h000);
    step(); check_fetch("run1", 12'h000, 12'h002);
    step(); check_fetch("run2", 12'h002, 12'h004);
    step(); check_fetch("run3", 12'h004, 12'h006);

    // Stall three cycles at pc 0x006
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_fetch("stall", 12'h004, 12'h006);
    end
    bus.stall = 1'b0;
    step(); check_fetch("resume0", 12'h006, 12'h008);
    step(); check_fetch("resume1", 12'h008, 12'h00A);

    // Branch to odd target under stall; zero-count loop_set is ignored
    bus.stall = 1'b1;
    bus.br_valid = 1'b1;
    bus.br_target = 12'h103;
    bus.loop_set = 1'b1;
    bus.loop_start = 12'h040;
    bus.loop_end = 12'h044;
    bus.loop_count = '0;
    step();
    check("br.addr",    32'(bus.imem_addr), 32'h102);
    check("br.valid",   32'(bus.if_valid), 32'd0);
    check("cnt0.active", 32'(bus.loop_active), 32'd0);
    check("cnt0.err",   32'(bus.loop_err), 32'd0);
    bus.stall = 1'b0;
    bus.br_valid = 1'b0;
    bus.loop_set = 1'b0;
    step(); check_fetch("br.after", 12'h102, 12'h104);

    // Hardware loop 0x010..0x014, three iterations, armed with a branch to its start
    bus.br_valid = 1'b1;
    bus.br_target = 12'h010;
    bus.loop_set = 1'b1;
    bus.loop_start = 12'h010;
    bus.loop_end = 12'h015;
    bus.loop_count = 10'd3;
    step();
    check("lp.addr",   32'(bus.imem_addr), 32'h010);
    check("lp.valid",  32'(bus.if_valid), 32'd0);
    check("lp.active", 32'(bus.loop_active), 32'd1);
    bus.br_valid = 1'b0;
    bus.loop_set = 1'b0;
    for (int i = 0; i < 11; i++) begin
      // A second load while armed must only raise the sticky error.
      if (i == 4) begin
        bus.loop_set = 1'b1;
        bus.loop_start = 12'h020;
        bus.loop_end = 12'h012;
        bus.loop_count = 10'd5;
      end
      step();
      bus.loop_set = 1'b0;
      check($sformatf("lp%0d.valid", i),  32'(bus.if_valid), 32'd1);
      check($sformatf("lp%0d.if_pc", i),  32'(bus.if_pc), 32'(loop_pc[i]));
      check($sformatf("lp%0d.instr", i),  32'(bus.if_instr), 32'(loop_pc[i]));
      check($sformatf("lp%0d.active", i), 32'(bus.loop_active), 32'(loop_act[i]));
      check($sformatf("lp%0d.err", i),    32'(bus.loop_err), (i >= 4) ? 32'd1 : 32'd0);
    end
    check("lp.end.addr", 32'(bus.imem_addr), 32'h01A);

    // Wrap at the top of the address space
    bus.br_valid = 1'b1;
    bus.br_target = 12'hFFC;
    step();
    check("wrap.addr",  32'(bus.imem_addr), 32'hFFC);
    check("wrap.valid", 32'(bus.if_valid), 32'd0);
    bus.br_valid = 1'b0;
    step(); check_fetch("wrap0", 12'hFFC, 12'hFFE);
    step(); check_fetch("wrap1", 12'hFFE, 12'h000);
    step(); check_fetch("wrap2", 12'h000, 12'h002);

    // Arm a new loop, then reset asynchronously mid-loop
    bus.loop_set = 1'b1;
    bus.loop_start = 12'h004;
    bus.loop_end = 12'h008;
    bus.loop_count = 10'd2;
    step();
    bus.loop_set = 1'b0;
    check("rl.active", 32'(bus.loop_active), 32'd1);
    check_fetch("rl0", 12'h002, 12'h004);
    step(); check_fetch("rl1", 12'h004, 12'h006);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.addr",   32'(bus.imem_addr), 32'h000);
    check("arst.valid",  32'(bus.if_valid), 32'd0);
    check("arst.if_pc",  32'(bus.if_pc), 32'h000);
    check("arst.instr",  32'(bus.if_instr), 32'h000);
    check("arst.active", 32'(bus.loop_active), 32'd0);
    check("arst.err",    32'(bus.loop_err), 32'd0);

    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
